// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: start/busy/done handshake and operand bus for the multi-cycle shifter
// master drives start, val_rm, shift_type, amount, carry_in; slave returns busy, done, result, carry_out
interface shift_seq_ctrl_if;
  logic        start;
  logic [31:0] val_rm;
  logic [1:0]  shift_type;
  logic [7:0]  amount;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  modport master (output start, val_rm, shift_type, amount, carry_in, input busy, done, result, carry_out);
  modport slave  (input start, val_rm, shift_type, amount, carry_in, output busy, done, result, carry_out);
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle register-specified ARM shift, at most STEP bits per cycle
// ports: clk, rst (sync, active-high); bus (slave): start/val_rm/shift_type/amount/carry_in in,
// busy/done/result/carry_out out
module shift_seq_ctrl #(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_seq_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [5:0] STEP6 = 6'(STEP);
  state_t      r_state, w_next;
  logic [31:0] r_val, w_val, w_ror;
  logic        r_carry, w_c;
  logic [1:0]  r_type;
  logic [5:0]  r_rem, w_chunk, w_rem_nxt, w_eff;
  logic [32:0] w_lsl, w_lsr, w_asr;
  always_comb begin
    w_chunk   = (r_rem < STEP6) ? r_rem : STEP6;
    w_rem_nxt = r_rem - w_chunk;
    // a zero ROR count with nonzero amount behaves like amount==0 except for the carry source
    w_eff = (bus.amount == 8'd0) ? 6'd0 :
            (bus.shift_type == 2'b11) ? {1'b0, bus.amount[4:0]} :
            (bus.shift_type == 2'b10) ? ((bus.amount > 8'd32) ? 6'd32 : bus.amount[5:0]) :
            ((bus.amount > 8'd33) ? 6'd33 : bus.amount[5:0]);
    // the extra bit on each side captures the last bit shifted out of the chunk
    w_lsl = {1'b0, r_val} << w_chunk;
    w_lsr = {r_val, 1'b0} >> w_chunk;
    w_asr = $signed({r_val, 1'b0}) >>> w_chunk;
    w_ror = (r_val >> w_chunk) | (r_val << (6'd32 - w_chunk));
    w_val = (r_type == 2'b00) ? w_lsl[31:0] :
            (r_type == 2'b01) ? w_lsr[32:1] :
            (r_type == 2'b10) ? w_asr[32:1] : w_ror;
    w_c   = (r_type == 2'b00) ? w_lsl[32] :
            (r_type == 2'b01) ? w_lsr[0] :
            (r_type == 2'b10) ? w_asr[0] : w_ror[31];
    w_next = (r_state == IDLE)  ? (bus.start ? ((w_eff != 6'd0) ? SHIFT : DONE) : IDLE) :
             (r_state == SHIFT) ? ((w_rem_nxt != 6'd0) ? SHIFT : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_val   <= '0;
      r_carry <= 1'b0;
      r_type  <= 2'b00;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_val   <= bus.val_rm;
        r_type  <= bus.shift_type;
        r_rem   <= w_eff;
        r_carry <= (bus.shift_type == 2'b11 && bus.amount != 8'd0) ? bus.val_rm[31] : bus.carry_in;
      end else if (r_state == SHIFT) begin
        r_val   <= w_val;
        r_carry <= w_c;
        r_rem   <= w_rem_nxt;
      end
    end
  end
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.result    = r_val;
  assign bus.carry_out = r_carry;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed checks of shift_seq_ctrl results, carries, latency and handshake
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  shift_seq_ctrl_if bus ();
  shift_seq_ctrl #(.STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [1:0] t, input logic [31:0] v, input logic [7:0] a,
                    input logic c, input int lat, input logic [31:0] er, input logic ec);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.shift_type = t; bus.val_rm = v; bus.amount = a; bus.carry_in = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.val_rm = ~v; bus.amount = 8'd7; bus.carry_in = ~c; bus.shift_type = ~t;
    chk({tag, " busy_first"}, 32'(bus.busy), 32'd1);
    n = 1;
    while (!bus.done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd1);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " carry"}, 32'(bus.carry_out), 32'(ec));
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    chk({tag, " result_held"}, bus.result, er);
  endtask
  initial begin
    int dones;
    bus.start = 1'b0; bus.val_rm = '0; bus.shift_type = 2'b00; bus.amount = '0; bus.carry_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset carry", 32'(bus.carry_out), 32'd0);
    @(negedge clk); rst = 1'b0;
    op("lsl1",    2'b00, 32'h80000001, 8'd1,   1'b0, 2,  32'h00000002, 1'b1);
    op("lsr32",   2'b01, 32'h80000000, 8'd32,  1'b0, 9,  32'h00000000, 1'b1);
    op("lsl33",   2'b00, 32'hFFFFFFFF, 8'd33,  1'b1, 10, 32'h00000000, 1'b0);
    op("asr40",   2'b10, 32'h80000000, 8'd40,  1'b0, 9,  32'hFFFFFFFF, 1'b1);
    op("asr200",  2'b10, 32'h40000000, 8'd200, 1'b1, 9,  32'h00000000, 1'b0);
    op("ror4",    2'b11, 32'h000000F1, 8'd4,   1'b1, 2,  32'h1000000F, 1'b0);
    op("ror32",   2'b11, 32'h80000000, 8'd32,  1'b0, 1,  32'h80000000, 1'b1);
    op("amt0",    2'b01, 32'h12345678, 8'd0,   1'b1, 1,  32'h12345678, 1'b1);
    op("ror5",    2'b11, 32'h00000010, 8'd5,   1'b0, 3,  32'h80000000, 1'b1);
    op("lsl32",   2'b00, 32'h00000001, 8'd32,  1'b0, 9,  32'h00000000, 1'b1);
    op("asr5",    2'b10, 32'h80000010, 8'd5,   1'b0, 3,  32'hFC000000, 1'b1);
    op("lsr3",    2'b01, 32'h0000000F, 8'd3,   1'b0, 2,  32'h00000001, 1'b1);
    op("lsl300",  2'b00, 32'hFFFFFFFF, 8'd255, 1'b1, 10, 32'h00000000, 1'b0);
    // start held high: accepted once, the copy seen in DONE is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.shift_type = 2'b00; bus.val_rm = 32'h00000001; bus.amount = 8'd4; bus.carry_in = 1'b0;
    dones = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
      if (k == 2) chk("hold result", bus.result, 32'h00000010);
    end
    bus.start = 1'b0;
    chk("hold idle_n3", {30'd0, bus.busy, bus.done}, 32'd0);
    @(posedge clk); #1;
    chk("hold no_retrigger", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("hold done_count", 32'(dones), 32'd1);
    // reset during SHIFT aborts without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.shift_type = 2'b00; bus.val_rm = 32'hA5A5A5A5; bus.amount = 8'd20; bus.carry_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("abort busy_mid", 32'(bus.busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort result", bus.result, 32'd0);
    chk("abort carry", 32'(bus.carry_out), 32'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    op("after_abort", 2'b01, 32'hF0000000, 8'd4, 1'b0, 2, 32'h0F000000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer for register-specified shifts in the EXE stage. The count comes from Rs[7:0] and can reach 255, which the single-cycle immediate-shift path does not handle. It shifts val_rm by at most STEP bits per cycle and produces the ARM shifter result plus the shifter carry-out. A start/busy/done handshake lets the hazard/stall unit freeze the pipeline while the operation runs.

Parameters:
STEP, 4, maximum bits shifted per cycle; power of two, 1..16.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
val_rm  input  32  operand to shift; captured on accepted start
shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; captured on start
amount  input  8  shift count Rs[7:0]; captured on start
carry_in  input  1  current C flag; captured on start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result and carry_out are valid
result  output  32  shifted value; held until the next accepted start
carry_out  output  1  shifter carry-out; held with result

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, carry_out=0. Any in-flight operation is aborted with no done pulse.
- States and transitions:
  - IDLE -> (start) SHIFT if eff>0, else DONE.
  - SHIFT -> SHIFT while remaining>0 after this cycle's chunk; -> DONE when remaining reaches 0.
  - DONE -> IDLE unconditionally.
- start is ignored in SHIFT and DONE. A start sampled in the DONE cycle is dropped, not queued.
- Effective count eff, computed at start:
  - amount==0 (any type): eff=0; result=val_rm; carry_out=carry_in.
  - LSL/LSR: eff=min(amount,33).
  - ASR: eff=min(amount,32).
  - ROR: eff=amount[4:0].
  - ROR with amount!=0 and amount[4:0]==0: eff=0; result=val_rm; carry_out=val_rm[31].
- Each SHIFT cycle: chunk=min(STEP,remaining); remaining-=chunk.
  - LSL/LSR: zero fill.
  - ASR: sign fill.
  - ROR: rotate right.
  - Shift carry_out = last bit shifted out in the chunk. LSL: bit [32-chunk] of the pre-chunk value. LSR/ASR: bit [chunk-1].
  - ROR carry_out = result[31] after the final chunk.
- Derived outcomes:
  - LSL/LSR 32: result 0; carry = val_rm[0] / val_rm[31].
  - LSL/LSR 33..255: result 0, carry 0.
  - ASR >=32: all bits and carry = val_rm[31].
- Latency: with start accepted at edge N, done is high in cycle N+1+ceil(eff/STEP). This is N+1 for eff=0.
- busy rises in the cycle after the accepted start and falls in the cycle after done.
- result and carry_out update only in SHIFT/DONE and stay stable from done until the next accepted start. The input ports may change freely once start is accepted.
- Only the captured copy is used; inputs are not re-sampled mid-operation.

Test Plan:
- STEP=4, LSL 0x80000001 by 1 -> result 0x00000002, carry_out 1, done at N+2, busy high for N+1..N+2.
- LSR 0x80000000 by 32 -> result 0x00000000, carry_out 1, done at N+9. Then LSL 0xFFFFFFFF by 33 -> result 0, carry_out 0, done at N+10.
- ASR 0x80000000 by 40 -> result 0xFFFFFFFF, carry_out 1, done at N+9. ASR 0x40000000 by 200 -> result 0, carry_out 0.
- ROR 0x000000F1 by 4 -> result 0x1000000F, carry_out 0, done at N+2. ROR 0x80000000 by 32 -> result 0x80000000, carry_out 1, done at N+1.
- amount=0 with carry_in=1, LSR 0x12345678 -> result 0x12345678, carry_out 1, done at N+1.
- Handshake: start held high through an operation -> exactly one done and no re-trigger until IDLE. rst asserted during SHIFT of LSL by 20 -> next cycle busy=0, done=0, result=0, and no done pulse follows.
